// File: rtl/hub75_pkg.sv
// hub75_pkg: shared word width and pixel word type for the HUB75 pixel path
package hub75_pkg;
  localparam int WORD_WIDTH = 16;
  typedef logic [WORD_WIDTH-1:0] pixel_word_t;
endpackage

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: mode-0 MSB-first SPI receiver emitting whole words with a one-cycle strobe
module spi_slave_rx #(
  parameter int WORD_WIDTH = hub75_pkg::WORD_WIDTH
) (
  input  logic                  spi_clk,
  input  logic                  reset,
  input  logic                  spi_mosi,
  output logic [WORD_WIDTH-1:0] data,
  output logic                  pixel_clock
);
  localparam int CW = $clog2(WORD_WIDTH);
  logic [WORD_WIDTH-1:0] shift_q, shift_d, data_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pixel_q, last;
  always_comb begin
    shift_d = {shift_q[WORD_WIDTH-2:0], spi_mosi};
    last = cnt_q == CW'(WORD_WIDTH - 1);
    cnt_d = last ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge spi_clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      pixel_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      pixel_q <= last;
      if (last) data_q <= shift_d;
    end
  end
  assign data = data_q;
  assign pixel_clock = pixel_q;
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed word streams with hand-computed results for spi_slave_rx
module tb_spi_slave_rx;
  logic spi_clk = 1'b0;
  logic reset = 1'b0;
  logic spi_mosi = 1'b0;
  logic [15:0] data;
  logic pixel_clock;
  int errors = 0;
  int checks = 0;

  spi_slave_rx dut (
    .spi_clk(spi_clk),
    .reset(reset),
    .spi_mosi(spi_mosi),
    .data(data),
    .pixel_clock(pixel_clock)
  );

  // MOSI changes while the clock is low; outputs are sampled 1 time unit after the rising edge
  task automatic tick(input logic b);
    spi_clk = 1'b0;
    #2 spi_mosi = b;
    #3 spi_clk = 1'b1;
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] exp_d, input logic exp_p);
    checks++;
    if (data !== exp_d || pixel_clock !== exp_p) begin
      errors++;
      $display("FAIL %s: data=%h pixel_clock=%b, expected data=%h pixel_clock=%b",
               name, data, pixel_clock, exp_d, exp_p);
    end
  endtask

  task automatic send_word(input logic [15:0] w, input logic [15:0] prev, input string name);
    for (int i = 15; i >= 0; i--) begin
      tick(w[i]);
      check($sformatf("%s bit%0d", name, 15 - i), i == 0 ? w : prev, i == 0);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(1'b1);
    check("reset", 16'h0000, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_single;
    send_word(16'h1234, 16'h0000, "single");
  endtask

  task automatic test_back_to_back;
    send_word(16'hA5A5, 16'h1234, "b2b_first");
    send_word(16'h0F0F, 16'hA5A5, "b2b_second");
  endtask

  task automatic test_reset_mid;
    logic [6:0] part;
    part = 7'b1011001;
    for (int i = 6; i >= 0; i--) begin
      tick(part[i]);
      check("mid_partial", 16'h0F0F, 1'b0);
    end
    reset = 1'b1;
    tick(1'b1);
    check("mid_reset", 16'h0000, 1'b0);
    reset = 1'b0;
    send_word(16'hBEEF, 16'h0000, "mid_beef");
  endtask

  task automatic test_extremes;
    send_word(16'hFFFF, 16'hBEEF, "ones");
    send_word(16'h0000, 16'hFFFF, "zeros");
  endtask

  task automatic test_hold;
    send_word(16'h5A3C, 16'h0000, "hold_word");
    for (int i = 0; i < 4; i++) begin
      #3 spi_mosi = ~spi_mosi;
      #1 check("hold_static", 16'h5A3C, 1'b1);
    end
    tick(1'b0);
    check("hold_release", 16'h5A3C, 1'b0);
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_reset_mid;
    test_extremes;
    test_hold;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- Receive-only SPI slave (mode 0, MSB first, no chip select) that deserialises a continuous MOSI bit stream into fixed-width words.
- Sits at the front of the HUB75 controller and feeds pixel words to the display datapath.
- Each completed word is presented on `data` together with a one-cycle `pixel_clock` strobe that downstream logic uses to capture it.

Parameters:
- WORD_WIDTH, 16, bits per received word and width of `data`.

Ports:
- spi_clk  input  1  SPI serial clock from the master; the block's only clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on rising spi_clk.
- spi_mosi  input  1  serial data, sampled on rising spi_clk.
- data  output  WORD_WIDTH  last completed word, registered.
- pixel_clock  output  1  word-complete strobe, registered.

Behaviour:
- One clock (spi_clk); reset is synchronous and active-high. Reset takes effect only on a rising spi_clk edge while reset=1.
- Reset values:
  - data = 0
  - pixel_clock = 0
  - internal shift register = 0
  - bit counter = 0
- Reset mid-word discards the partial word. The next non-reset edge is bit 0 of a new word.
- Reset has priority over shifting on the same edge; spi_mosi is ignored on that edge.
- Sampling: on each non-reset rising edge, shift <= {shift[WORD_WIDTH-2:0], spi_mosi}. The first bit received is the MSB.
- Bit counter (width clog2(WORD_WIDTH)) increments each non-reset edge and wraps WORD_WIDTH-1 -> 0.
- Word completion is the edge where the counter = WORD_WIDTH-1. On that same edge:
  - data <= {shift[WORD_WIDTH-2:0], spi_mosi}, so data is valid immediately after the WORD_WIDTH-th edge (zero extra latency).
  - pixel_clock <= 1.
- On every other non-reset edge, pixel_clock <= 0. The strobe is therefore high for exactly one spi_clk period, from the completing edge to the next rising edge.
- If spi_clk stops after a word, pixel_clock stays high until the next edge.
- data holds its value between completions and is never partially updated.
- Back-to-back words: no gap is required. The edge after a completion is bit 0 of the next word, and pixel_clock falls on that edge.
- No framing or resynchronisation other than reset; the master must keep bit alignment.
- spi_mosi must be stable around the rising edge. The master changes it while spi_clk is low.

Decomposition:
- Shared package `hub75_pkg`: WORD_WIDTH default constant (16) and a `pixel_word_t` typedef of that width, reused by the downstream pixel path.
- No sub-module; a single module holding the shift register, counter and output registers is natural.

Test Plan:
- Reset: spi_mosi=1, reset=1 across one rising edge -> data=0x0000, pixel_clock=0.
- Single word: after reset, send 0x1234 MSB first on 16 edges (MOSI set while clock low) -> data=0x1234 immediately after edge 16; pixel_clock=1 only after edge 16, 0 after edges 1-15.
- Back-to-back: send 0xA5A5 then 0x0F0F with no gap -> data=0xA5A5 after edge 16, unchanged through edge 31, 0x0F0F after edge 32; pixel_clock high for exactly the periods following edges 16 and 32.
- Reset mid-word: send 7 bits, assert reset for one edge, then send 0xBEEF -> partial word discarded; data=0x0000 until 0xBEEF completes 16 edges after reset release, then data=0xBEEF.
- Extremes: words 0xFFFF then 0x0000 -> data exactly 0xFFFF then 0x0000; a pixel_clock strobe for each word.
- Hold: after a completed word, toggle spi_mosi with spi_clk static -> data and pixel_clock unchanged.
